// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per cycle, LSB first,
// and reports result, unsigned borrow, signed overflow and zero flags.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             accept;
  logic             last_bit;
  logic             diff_bit;
  logic             br_next;
  logic [WIDTH-1:0] result_next;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and one-bit full-subtractor slice
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    last_bit    = 1'b0;
    diff_bit    = a_sr[0] ^ b_sr[0] ^ br;
    br_next     = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    result_next = {diff_bit, result[WIDTH-1:1]};
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
          accept     = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == CW'(WIDTH - 1)) begin
          state_next = DONE;
          last_bit   = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_next = SHIFT;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand shifters, borrow chain, result and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      result   <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      busy <= (state_next == SHIFT);
      done <= (state_next == DONE);
      if (accept) begin
        a_sr <= a;
        b_sr <= b;
        cnt  <= '0;
        br   <= 1'b0;
      end else if (state == SHIFT) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        cnt    <= cnt + CW'(1);
        br     <= br_next;
        result <= result_next;
        // On the final bit a_sr[0]/b_sr[0] are the operand sign bits
        if (last_bit) begin
          borrow   <= br_next;
          overflow <= (a_sr[0] != b_sr[0]) && (diff_bit != a_sr[0]);
          zero     <= (result_next == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, randomized
// operations (WIDTH=8) and an exhaustive back-to-back sweep (WIDTH=4).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic       busy8, done8, borrow8, overflow8, zero8;
  logic [7:0] result8;
  logic       busy4, done4, borrow4, overflow4, zero4;
  logic [3:0] result4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8),
    .borrow(borrow8), .overflow(overflow8), .zero(zero8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4),
    .borrow(borrow4), .overflow(overflow4), .zero(zero4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction with signed range check
  task automatic ref_sub(input int w, input int unsigned x, input int unsigned y,
                         output logic [31:0] r, output logic br, output logic ov,
                         output logic z);
    int unsigned mask;
    int sx, sy, sd;
    mask = (32'd1 << w) - 32'd1;
    r    = (x - y) & mask;
    br   = (x < y);
    sx   = (x >= (32'd1 << (w - 1))) ? int'(x) - (1 << w) : int'(x);
    sy   = (y >= (32'd1 << (w - 1))) ? int'(y) - (1 << w) : int'(y);
    sd   = sx - sy;
    ov   = (sd < -(1 << (w - 1))) || (sd > (1 << (w - 1)) - 1);
    z    = (r == 32'd0);
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        n = k;
        break;
      end
    end
  endtask

  // One operation on the 8-bit instance; operands are scrambled after E0
  task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y);
    int n;
    logic [31:0] er;
    logic eb, eo, ez;
    @(negedge clk);
    a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    chk({tag, "_busy"}, 32'(busy8), 32'd1);
    wait_done8(n);
    chk({tag, "_latency"}, 32'(n), 32'd8);
    ref_sub(8, 32'(x), 32'(y), er, eb, eo, ez);
    chk({tag, "_result"}, 32'(result8), er);
    chk({tag, "_flags"}, 32'({borrow8, overflow8, zero8, busy8}), 32'({eb, eo, ez, 1'b0}));
    @(posedge clk); #1;
    chk({tag, "_hold"}, 32'({done8, result8, borrow8, overflow8, zero8}),
        32'({1'b0, er[7:0], eb, eo, ez}));
  endtask

  initial begin
    int n, seen;
    logic [31:0] er;
    logic eb, eo, ez;

    rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset8", 32'({busy8, done8, result8, borrow8, overflow8, zero8}), 32'd0);
    chk("reset4", 32'({busy4, done4, result4, borrow4, overflow4, zero4}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    op8("d_05_03", 8'h05, 8'h03);
    chk("d_05_03_const", 32'({result8, borrow8, overflow8, zero8}), 32'({8'h02, 3'b000}));
    op8("d_03_05", 8'h03, 8'h05);
    chk("d_03_05_const", 32'({result8, borrow8, overflow8, zero8}), 32'({8'hFE, 3'b100}));
    op8("d_80_01", 8'h80, 8'h01);
    chk("d_80_01_const", 32'({result8, borrow8, overflow8}), 32'({8'h7F, 2'b01}));
    op8("d_7f_ff", 8'h7F, 8'hFF);
    chk("d_7f_ff_const", 32'({result8, borrow8, overflow8}), 32'({8'h80, 2'b11}));

    // Equal operands, start ignored while busy, start accepted on done
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'hA5; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("busy_start_busy", 32'(busy8), 32'd1);
    wait_done8(n);
    chk("eq_latency", 32'(n + 2), 32'd8);
    chk("eq_result", 32'({result8, zero8, borrow8}), 32'({8'h00, 2'b10}));
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("b2b_no_gap", 32'({busy8, done8}), 32'({1'b1, 1'b0}));
    wait_done8(n);
    chk("b2b_latency", 32'(n), 32'd8);
    chk("b2b_result", 32'({result8, borrow8, overflow8, zero8}), 32'({8'h0F, 3'b000}));

    // Reset four cycles into an operation
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_outputs", 32'({busy8, done8, result8, borrow8, overflow8, zero8}), 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) seen = 1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    op8("post_reset", 8'h05, 8'h03);

    for (int i = 0; i < 40; i++) op8("rand", 8'($urandom), 8'($urandom));

    // Exhaustive WIDTH=4 sweep with start held high (back-to-back)
    @(negedge clk);
    a4 = 4'd0; b4 = 4'd0; start4 = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) begin
      n = 0;
      for (int k = 1; k <= 12; k++) begin
        @(posedge clk); #1;
        if (done4) begin
          n = k;
          break;
        end
      end
      chk("w4_latency", 32'(n), 32'd4);
      ref_sub(4, 32'(i >> 4), 32'(i & 15), er, eb, eo, ez);
      chk("w4_outputs", 32'({result4, borrow4, overflow4, zero4}), 32'({er[3:0], eb, eo, ez}));
      if (i < 255) begin
        a4 = 4'((i + 1) >> 4);
        b4 = 4'((i + 1) & 15);
        @(posedge clk); #1;
        chk("w4_no_gap", 32'(busy4), 32'd1);
      end else begin
        start4 = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
